if_id_skid: RTL and testbench

Parametrised IF/ID pipeline stage between instruction fetch and decode. It carries the PC and instruction word with a valid/ready handshake, so either side can stall without losing a fetched instruction. A synchronous flush invalidates everything in flight on branch or exception redirects. An optional two-entry skid buffer breaks the combinational ready path from decode back to fetch.

---
 rtl/if_id_skid.sv | 180 ++++++++++++++++++
 tb/tb_if_id_skid.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/if_id_skid.sv
// if_id_skid -- IF/ID pipeline stage with valid/ready handshake.
//
// Carries the fetched PC and instruction word from fetch to decode. Either
// side may stall without losing an instruction. A synchronous flush drops
// everything held plus any transfer offered in the same cycle.
//
// Build option (macro IF_ID_SKID_EN):
//   defined   : a second (skid) entry S is added and if_ready is derived
//               from registered state only, so there is no combinational
//               path from id_ready to if_ready.
//   undefined : single entry; if_ready = rst && (!id_valid || id_ready).
//
// Parameters:
//   ADDR_W   PC width in bits
//   INST_W   instruction width in bits
//   NOP_INST instruction word shown on id_inst while the stage is empty
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   rst      synchronous active-low reset
//   flush    invalidate held entries, drop this cycle's incoming transfer
//   if_valid fetch presents if_pc / if_inst
//   if_ready stage accepts a transfer this cycle
//   if_pc    fetched PC
//   if_inst  fetched instruction
//   id_valid id_pc / id_inst hold a valid instruction
//   id_ready decode consumes the instruction this cycle
//   id_pc    PC to decode (0 when empty)
//   id_inst  instruction to decode (NOP_INST when empty)
module if_id_skid #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter logic [INST_W-1:0]  NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst
);

`ifdef IF_ID_SKID_EN
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    ONE   = 1'b1
  } state_t;
`endif

  state_t state, state_nxt;

  logic              in_xfer;
  logic              out_xfer;
  logic              load_m;
  logic [ADDR_W-1:0] m_pc_p1;
  logic [INST_W-1:0] m_inst_p1;

`ifdef IF_ID_SKID_EN
  logic              load_s;
  logic              m_from_s;
  logic [ADDR_W-1:0] s_pc_p1;
  logic [INST_W-1:0] s_inst_p1;
`endif

  assign id_valid = (state != EMPTY);

`ifdef IF_ID_SKID_EN
  // Registered-only ready: the skid entry absorbs the one instruction that
  // may arrive in the cycle decode stalls.
  assign if_ready = rst && (state != TWO);
`else
  assign if_ready = rst && (!id_valid || id_ready);
`endif

  assign in_xfer  = if_valid && if_ready && !flush;
  assign out_xfer = id_valid && id_ready;

  // ---- stage p0 -> p1: next-state and load decisions ----
  always_comb begin
    state_nxt = state;
    load_m    = 1'b0;
`ifdef IF_ID_SKID_EN
    load_s    = 1'b0;
    m_from_s  = 1'b0;
`endif
    if (flush) begin
      // Any output transfer this cycle still completes; decode already
      // sampled M. Everything else is discarded.
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_nxt = ONE;
            load_m    = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            load_m = 1'b1;
          end else if (in_xfer) begin
`ifdef IF_ID_SKID_EN
            state_nxt = TWO;
            load_s    = 1'b1;
`else
            // Unreachable: without a skid entry if_ready implies out_xfer
            // whenever M is occupied.
            load_m    = 1'b1;
`endif
          end else if (out_xfer) begin
            state_nxt = EMPTY;
          end
        end
`ifdef IF_ID_SKID_EN
        TWO: begin
          if (out_xfer) begin
            state_nxt = ONE;
            m_from_s  = 1'b1;
          end
        end
`endif
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- stage p1: M / S data registers ----
  // Data is cleared on reset and flush so a discarded instruction cannot
  // linger in the registers.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      m_pc_p1   <= '0;
      m_inst_p1 <= NOP_INST;
`ifdef IF_ID_SKID_EN
      s_pc_p1   <= '0;
      s_inst_p1 <= NOP_INST;
`endif
    end else begin
      if (load_m) begin
        m_pc_p1   <= if_pc;
        m_inst_p1 <= if_inst;
      end
`ifdef IF_ID_SKID_EN
      else if (m_from_s) begin
        m_pc_p1   <= s_pc_p1;
        m_inst_p1 <= s_inst_p1;
      end
      if (load_s) begin
        s_pc_p1   <= if_pc;
        s_inst_p1 <= if_inst;
      end
`endif
    end
  end

  // M may hold a stale, already-consumed entry after ONE -> EMPTY, so the
  // outputs are masked by id_valid.
  assign id_pc   = id_valid ? m_pc_p1   : '0;
  assign id_inst = id_valid ? m_inst_p1 : NOP_INST;

endmodule

// File: tb/tb_if_id_skid.sv
// tb_if_id_skid -- self-checking bench for if_id_skid.
// Reference model: a FIFO queue of {pc, inst} whose capacity follows the
// build (two entries with IF_ID_SKID_EN, one without).
module tb_if_id_skid;
  localparam int                ADDR_W = 32;
  localparam int                INST_W = 32;
  localparam logic [INST_W-1:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              if_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;

  always #5 clk = ~clk;

  if_id_skid #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .NOP_INST (NOP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .id_pc    (id_pc),
    .id_inst  (id_inst)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } ent_t;

  ent_t  q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  string phase = "init";

  function automatic logic exp_if_ready();
`ifdef IF_ID_SKID_EN
    return rst && (q.size() < 2);
`else
    return rst && ((q.size() == 0) || id_ready);
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s.%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check after settling,
  // then advance the model at the rising edge.
  task automatic step(input logic r, input logic f, input logic v,
                      input logic [ADDR_W-1:0] pc, input logic [INST_W-1:0] inst,
                      input logic idr);
    logic acc, deq;
    ent_t e;
    @(negedge clk);
    rst = r; flush = f; if_valid = v; if_pc = pc; if_inst = inst; id_ready = idr;
    #1;
    chk("id_valid", 64'(id_valid), 64'(q.size() != 0));
    chk("id_pc",    64'(id_pc),    (q.size() != 0) ? 64'(q[0].pc)   : 64'd0);
    chk("id_inst",  64'(id_inst),  (q.size() != 0) ? 64'(q[0].inst) : 64'(NOP));
    chk("if_ready", 64'(if_ready), 64'(exp_if_ready()));
    acc = v && exp_if_ready() && !f;
    deq = (q.size() != 0) && idr;
    @(posedge clk);
    if (!r || f) begin
      q.delete();
    end else begin
      if (deq) void'(q.pop_front());
      if (acc) begin
        e.pc = pc; e.inst = inst;
        q.push_back(e);
      end
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; id_ready = 1'b0;
    @(posedge clk);

    phase = "reset";
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    phase = "stream";
    step(1'b1, 1'b0, 1'b1, 32'h0, 32'h24010001, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h4, 32'h24020002, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h8, 32'h00221820, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        1'b1);

    phase = "backpressure";
    step(1'b1, 1'b0, 1'b1, 32'h0, 32'h24010001, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h4, 32'h24020002, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h8, 32'h00221820, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h8, 32'h00221820, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h8, 32'h00221820, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h8, 32'h00221820, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        1'b1);

    phase = "flush_two";
    step(1'b1, 1'b0, 1'b1, 32'h0, 32'h24010001, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h4, 32'h24020002, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'hC, 32'h11111111, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        1'b1);

    phase = "flush_out";
    step(1'b1, 1'b0, 1'b1, 32'h20, 32'h22222222, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h24, 32'h33333333, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1);

    phase = "ready_drop";
    step(1'b1, 1'b0, 1'b1, 32'h40, 32'h44440000, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h44, 32'h44440001, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h44, 32'h44440001, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h48, 32'h44440002, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1);

    phase = "reset_mid";
    step(1'b1, 1'b0, 1'b1, 32'h60, 32'h55550000, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h64, 32'h55550001, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h68, 32'h55550002, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1);

    phase = "random";
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) >= 2),
           ($urandom_range(0, 99) < 6),
           ($urandom_range(0, 99) < 70),
           ADDR_W'($urandom() & 32'hFFFF_FFFC),
           INST_W'($urandom()),
           ($urandom_range(0, 99) < 60));
    end

    phase = "drain";
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
